// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory request FSM and IF/ID register.
// Optional FETCH_MISALIGN_CHK_EN: force redirect targets word-aligned and raise sticky MisalignF.
//
// state | meaning
// FETCH | request outstanding to PCF
// HOLD  | word received while decode stalled, held in one-entry buffer
// DROP  | wrong-path request outstanding, its response is discarded
module fetch_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic [31:0] ImemRdata,
  input  logic        ImemValid,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignF
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;

  state_t      r_state;
  logic [31:0] r_pcf;
  logic [31:0] r_req_addr;
  logic        r_req;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;

  logic        w_done;
  logic [31:0] w_tgt;
  logic        w_load_valid;
  logic [31:0] w_load_instr;
  logic [31:0] w_load_pc;

  assign w_done = r_req & ImemValid;

`ifdef FETCH_MISALIGN_CHK_EN
  logic r_misalign;

  assign w_tgt     = {PCTargetE[31:2], 2'b00};
  assign MisalignF = r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_misalign <= 1'b0;
    else if (PCSrcE && (PCTargetE[1:0] != 2'b00))
      r_misalign <= 1'b1;
  end
`else
  assign w_tgt     = PCTargetE;
  assign MisalignF = 1'b0;
`endif

  // A word may enter IF/ID only from a live FETCH completion or from the buffer,
  // and never in a cycle that redirects.
  assign w_load_valid = !PCSrcE && ((r_state == FETCH && w_done) || r_state == HOLD);
  assign w_load_instr = (r_state == HOLD) ? r_buf_instr : ImemRdata;
  assign w_load_pc    = (r_state == HOLD) ? r_buf_pc : r_req_addr;

  assign ImemReq  = r_req;
  assign ImemAddr = r_req_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= FETCH;
      r_pcf       <= 32'h0;
      r_req_addr  <= 32'h0;
      r_req       <= 1'b0;
      r_buf_instr <= 32'h0;
      r_buf_pc    <= 32'h0;
    end else begin
      case (r_state)
        FETCH: begin
          if (!r_req) begin
            // first cycle out of reset: issue the request to PCF
            r_req <= 1'b1;
            if (PCSrcE) begin
              r_pcf      <= w_tgt;
              r_req_addr <= w_tgt;
            end else begin
              r_req_addr <= r_pcf;
            end
          end else if (w_done) begin
            if (PCSrcE) begin
              r_pcf      <= w_tgt;
              r_req_addr <= w_tgt;
            end else if (StallD) begin
              r_buf_instr <= ImemRdata;
              r_buf_pc    <= r_req_addr;
              r_pcf       <= r_pcf + 32'd4;
              r_req       <= 1'b0;
              r_state     <= HOLD;
            end else begin
              r_pcf      <= r_pcf + 32'd4;
              r_req_addr <= r_pcf + 32'd4;
            end
          end else if (PCSrcE) begin
            r_pcf   <= w_tgt;
            r_state <= DROP;
          end
        end
        HOLD: begin
          if (PCSrcE) begin
            r_pcf      <= w_tgt;
            r_req_addr <= w_tgt;
            r_req      <= 1'b1;
            r_state    <= FETCH;
          end else if (!StallD) begin
            r_req_addr <= r_pcf;
            r_req      <= 1'b1;
            r_state    <= FETCH;
          end
        end
        DROP: begin
          if (PCSrcE)
            r_pcf <= w_tgt;
          if (w_done) begin
            r_req_addr <= PCSrcE ? w_tgt : r_pcf;
            r_state    <= FETCH;
          end
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  // IF/ID register: flush beats stall beats load; no word means a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      InstrD   <= NOP;
      PCD      <= 32'h0;
      PCPlus4D <= 32'h0;
      ValidD   <= 1'b0;
    end else if (FlushD) begin
      InstrD <= NOP;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      if (w_load_valid) begin
        InstrD   <= w_load_instr;
        PCD      <= w_load_pc;
        PCPlus4D <= w_load_pc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD <= NOP;
        ValidD <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory returns address-tagged words.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallD = 1'b0;
  logic        FlushD = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] PCTargetE = 32'h0;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic [31:0] ImemRdata;
  logic        ImemValid = 1'b0;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        MisalignF;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .ImemReq(ImemReq), .ImemAddr(ImemAddr), .ImemRdata(ImemRdata),
    .ImemValid(ImemValid), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .ValidD(ValidD), .MisalignF(MisalignF)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign ImemRdata = tag(ImemAddr);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic valid);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    ImemValid = valid;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    do_reset(1'b1);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ImemReq !== 1'b0) begin failures++; $display("FAIL rst_req got=%b exp=0", ImemReq); end
    checks++; if (ImemAddr !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", ImemAddr); end
    checks++; if (InstrD !== NOP) begin failures++; $display("FAIL rst_instr got=%h exp=%h", InstrD, NOP); end
    checks++; if (PCD !== 32'h0 || PCPlus4D !== 32'h0) begin failures++; $display("FAIL rst_pc got=%h/%h exp=0/0", PCD, PCPlus4D); end
    checks++; if (ValidD !== 1'b0 || MisalignF !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", ValidD, MisalignF); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0) begin failures++; $display("FAIL post_rst_req got=%b/%h exp=1/0", ImemReq, ImemAddr); end
    checks++; if (ValidD !== 1'b0) begin failures++; $display("FAIL post_rst_novalid got=%b exp=0", ValidD); end
  endtask

  task automatic test_stream;
    do_reset(1'b1);
    tick();
    checks++; if (ImemAddr !== 32'h0) begin failures++; $display("FAIL stream_a0 got=%h exp=0", ImemAddr); end
    tick();
    checks++; if (ImemAddr !== 32'h4) begin failures++; $display("FAIL stream_a4 got=%h exp=4", ImemAddr); end
    checks++; if (InstrD !== tag(32'h0) || PCD !== 32'h0 || PCPlus4D !== 32'h4 || ValidD !== 1'b1) begin
      failures++; $display("FAIL stream_w0 got=%h/%h/%h/%b exp=%h/0/4/1", InstrD, PCD, PCPlus4D, ValidD, tag(32'h0)); end
    tick();
    checks++; if (ImemAddr !== 32'h8 || PCD !== 32'h4 || InstrD !== tag(32'h4)) begin
      failures++; $display("FAIL stream_a8 got=%h/%h/%h exp=8/4/%h", ImemAddr, PCD, InstrD, tag(32'h4)); end
  endtask

  task automatic test_wait;
    do_reset(1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h0 || ValidD !== 1'b0 || InstrD !== NOP) begin
        failures++; $display("FAIL wait_bubble%0d got=%b/%h/%b/%h exp=1/0/0/%h", i, ImemReq, ImemAddr, ValidD, InstrD, NOP); end
    end
    ImemValid = 1'b1;
    tick();
    checks++; if (InstrD !== tag(32'h0) || ValidD !== 1'b1 || ImemAddr !== 32'h4) begin
      failures++; $display("FAIL wait_load got=%h/%b/%h exp=%h/1/4", InstrD, ValidD, ImemAddr, tag(32'h0)); end
  endtask

  task automatic test_stall;
    do_reset(1'b1);
    tick();
    tick();
    StallD = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ImemReq !== 1'b0 || PCD !== 32'h0 || InstrD !== tag(32'h0) || ValidD !== 1'b1) begin
        failures++; $display("FAIL stall_hold%0d got=%b/%h/%h/%b exp=0/0/%h/1", i, ImemReq, PCD, InstrD, ValidD, tag(32'h0)); end
    end
    StallD = 1'b0;
    tick();
    checks++; if (InstrD !== tag(32'h4) || PCD !== 32'h4 || ValidD !== 1'b1) begin
      failures++; $display("FAIL stall_buf got=%h/%h/%b exp=%h/4/1", InstrD, PCD, ValidD, tag(32'h4)); end
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h8) begin failures++; $display("FAIL stall_next got=%b/%h exp=1/8", ImemReq, ImemAddr); end
    tick();
    checks++; if (InstrD !== tag(32'h8) || PCD !== 32'h8) begin failures++; $display("FAIL stall_after got=%h/%h exp=%h/8", InstrD, PCD, tag(32'h8)); end
  endtask

  task automatic test_redirect_drop;
    do_reset(1'b1);
    for (int i = 0; i < 9; i++) tick();
    checks++; if (ImemAddr !== 32'h20) begin failures++; $display("FAIL drop_pre got=%h exp=20", ImemAddr); end
    ImemValid = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h100;
    tick();
    PCSrcE = 1'b0;
    checks++; if (ImemReq !== 1'b1 || ImemAddr !== 32'h20 || ValidD !== 1'b0) begin
      failures++; $display("FAIL drop_hold got=%b/%h/%b exp=1/20/0", ImemReq, ImemAddr, ValidD); end
    tick();
    ImemValid = 1'b1;
    tick();
    checks++; if (ImemAddr !== 32'h100 || ValidD !== 1'b0 || InstrD !== NOP) begin
      failures++; $display("FAIL drop_discard got=%h/%b/%h exp=100/0/%h", ImemAddr, ValidD, InstrD, NOP); end
    tick();
    checks++; if (InstrD !== tag(32'h100) || PCD !== 32'h100 || ValidD !== 1'b1 || ImemAddr !== 32'h104) begin
      failures++; $display("FAIL drop_target got=%h/%h/%b/%h exp=%h/100/1/104", InstrD, PCD, ValidD, ImemAddr, tag(32'h100)); end
  endtask

  task automatic test_flush_stall;
    do_reset(1'b1);
    tick();
    tick();
    FlushD = 1'b1; StallD = 1'b1;
    tick();
    checks++; if (InstrD !== NOP || ValidD !== 1'b0 || ImemReq !== 1'b0) begin
      failures++; $display("FAIL flush_bubble got=%h/%b/%b exp=%h/0/0", InstrD, ValidD, ImemReq, NOP); end
    FlushD = 1'b0; StallD = 1'b0;
    tick();
    checks++; if (InstrD !== tag(32'h4) || PCD !== 32'h4 || ValidD !== 1'b1 || ImemAddr !== 32'h8) begin
      failures++; $display("FAIL flush_resume got=%h/%h/%b/%h exp=%h/4/1/8", InstrD, PCD, ValidD, ImemAddr, tag(32'h4)); end
  endtask

  task automatic test_hold_redirect;
    do_reset(1'b1);
    tick();
    StallD = 1'b1;
    tick();
    StallD = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h40;
    tick();
    PCSrcE = 1'b0;
    checks++; if (ValidD !== 1'b0 || ImemReq !== 1'b1 || ImemAddr !== 32'h40) begin
      failures++; $display("FAIL holdredir_discard got=%b/%b/%h exp=0/1/40", ValidD, ImemReq, ImemAddr); end
    tick();
    checks++; if (InstrD !== tag(32'h40) || PCD !== 32'h40 || ValidD !== 1'b1) begin
      failures++; $display("FAIL holdredir_load got=%h/%h/%b exp=%h/40/1", InstrD, PCD, ValidD, tag(32'h40)); end
  endtask

  task automatic test_wrap;
    do_reset(1'b1);
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFC;
    tick();
    PCSrcE = 1'b0;
    checks++; if (ImemAddr !== 32'hFFFF_FFFC || ValidD !== 1'b0) begin
      failures++; $display("FAIL wrap_redir got=%h/%b exp=fffffffc/0", ImemAddr, ValidD); end
    tick();
    checks++; if (PCD !== 32'hFFFF_FFFC || PCPlus4D !== 32'h0 || ImemAddr !== 32'h0 || InstrD !== tag(32'hFFFF_FFFC)) begin
      failures++; $display("FAIL wrap_pc got=%h/%h/%h/%h exp=fffffffc/0/0/%h", PCD, PCPlus4D, ImemAddr, InstrD, tag(32'hFFFF_FFFC)); end
  endtask

  task automatic test_misalign;
    logic [31:0] exp_addr;
    logic        exp_mis;
`ifdef FETCH_MISALIGN_CHK_EN
    exp_addr = 32'h100; exp_mis = 1'b1;
`else
    exp_addr = 32'h102; exp_mis = 1'b0;
`endif
    do_reset(1'b1);
    tick();
    PCSrcE = 1'b1; PCTargetE = 32'h102;
    tick();
    PCSrcE = 1'b0;
    checks++; if (ImemAddr !== exp_addr || MisalignF !== exp_mis) begin
      failures++; $display("FAIL misalign_redir got=%h/%b exp=%h/%b", ImemAddr, MisalignF, exp_addr, exp_mis); end
    tick();
    tick();
    checks++; if (MisalignF !== exp_mis) begin failures++; $display("FAIL misalign_sticky got=%b exp=%b", MisalignF, exp_mis); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (MisalignF !== 1'b0) begin failures++; $display("FAIL misalign_clear got=%b exp=0", MisalignF); end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect_drop();
    test_flush_stall();
    test_hold_redirect();
    test_wrap();
    test_misalign();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
